adder_pipe_vr: RTL and testbench

- Parametrised, pipelined add/subtract unit with carry-in, carry-out and signed-overflow flag.
- Successor to the fixed 4-bit combinational adder. Its output timing is set by a registered pipeline of STAGES clock cycles, not by modelled delays.
- Uses valid/ready handshakes on input and output, so it can sit between elastic datapath blocks and stall cleanly.

---
 rtl/adder_pipe_vr.sv | 102 ++++++++++
 tb/tb_adder_pipe_vr.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_vr.sv
// adder_pipe_vr: pipelined add/subtract unit with carry-in, carry-out and
// two's-complement overflow. The result moves through STAGES registered stages
// under valid/ready handshakes. All stages stall together.
//
// Ports:
//   clk        in   single clock, rising-edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand set valid
//   in_ready   out  operand set accepted this cycle (pure function of output side)
//   a, b       in   WIDTH-bit operands
//   ci         in   carry-in (add) / borrow-in (sub)
//   sub        in   0 = add, 1 = subtract
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   sum        out  WIDTH-bit result
//   co         out  raw adder carry-out (no-borrow when subtracting)
//   ovf        out  signed overflow
//   busy       out  any stage holds a valid entry
module adder_pipe_vr #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             busy
);

    if (WIDTH < 1) begin : g_bad_width
        $error("adder_pipe_vr: WIDTH must be >= 1");
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("adder_pipe_vr: STAGES must be >= 1");
    end

    // Payload layout: {co, ovf, sum}
    localparam int PW = WIDTH + 2;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH:0]   raw_sum;
    logic             ovf_calc;
    logic [PW-1:0]    payload_d;
    logic             adv;
    logic             xfer;

    logic [STAGES-1:0] valid_q;
    logic [PW-1:0]     payload_q [STAGES];

    // Subtraction is a + ~b + !ci, so a borrow-in becomes a missing +1.
    assign b_eff     = sub ? ~b : b;
    assign cin_eff   = sub ? ~ci : ci;
    assign raw_sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
    assign ovf_calc  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (raw_sum[WIDTH-1] != a[WIDTH-1]);
    assign payload_d = {raw_sum[WIDTH], ovf_calc, raw_sum[WIDTH-1:0]};

    // Global stall: the whole pipe moves only when the last stage can empty.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign xfer     = in_valid && adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q[0]   <= 1'b0;
            payload_q[0] <= '0;
        end else if (adv) begin
            valid_q[0] <= xfer;
            // Payload only loads on a real transfer so undriven operands
            // during bubbles never reach the stage registers.
            if (xfer) begin
                payload_q[0] <= payload_d;
            end
        end
    end

    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q[g]   <= 1'b0;
                payload_q[g] <= '0;
            end else if (adv) begin
                valid_q[g]   <= valid_q[g-1];
                payload_q[g] <= payload_q[g-1];
            end
        end
    end

    assign out_valid        = valid_q[STAGES-1];
    assign {co, ovf, sum}   = payload_q[STAGES-1];
    assign busy             = |valid_q;

endmodule

// File: tb/tb_adder_pipe_vr.sv
module tb_adder_pipe_vr;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] sum;
    logic       co;
    logic       ovf;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_out   = 0;

    logic [5:0] q_main[$];
    logic [5:0] cur_exp;
    logic [5:0] mon_exp;

    adder_pipe_vr #(.WIDTH(4), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .ovf(ovf), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference arithmetic done in wide signed integers; returns {co, ovf, sum[15:0]}.
    function automatic logic [17:0] ref_model(input int w, input logic [15:0] ta,
                                              input logic [15:0] tbv, input logic tci,
                                              input logic tsub);
        longint ua, ub, sa, sb, u, s, m, smax;
        logic   rco, rovf;
        ua   = longint'(ta);
        ub   = longint'(tbv);
        m    = (longint'(1) << w) - 1;
        smax = (longint'(1) << (w - 1)) - 1;
        sa   = ta[w-1]  ? ua - (m + 1) : ua;
        sb   = tbv[w-1] ? ub - (m + 1) : ub;
        if (tsub) begin
            u   = ua - ub - longint'(tci);
            s   = sa - sb - longint'(tci);
            rco = (u >= 0);
        end else begin
            u   = ua + ub + longint'(tci);
            s   = sa + sb + longint'(tci);
            rco = (u > m);
        end
        rovf = (s > smax) || (s < -smax - 1);
        return {rco, rovf, 16'(u & m)};
    endfunction

    function automatic logic [5:0] main_exp(input logic [3:0] ta, input logic [3:0] tbv,
                                            input logic tci, input logic tsub);
        logic [17:0] r;
        r = ref_model(4, 16'(ta), 16'(tbv), tci, tsub);
        return {r[17], r[16], r[3:0]};
    endfunction

    // Scoreboard for the main instance: compare on output acceptance, then
    // push on input transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (q_main.size() == 0) begin
                    chk("main_spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    mon_exp = q_main.pop_front();
                    chk("main_result", 32'({co, ovf, sum}), 32'(mon_exp));
                end
            end
            if (in_valid && in_ready) q_main.push_back(cur_exp);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [3:0] ta, input logic [3:0] tbv, input logic tci,
                        input logic tsub, input logic [5:0] e);
        int   n;
        logic rdy;
        a = ta; b = tbv; ci = tci; sub = tsub; cur_exp = e; in_valid = 1'b1;
        n = 0; rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!rdy) chk("send_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q_main.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 32'(q_main.size()), 32'd0);
    endtask

    // Parameter sweep instances: random traffic against the reference model.
    for (genvar k = 0; k < 4; k++) begin : g_sw
        localparam int SW = (k < 2) ? 1 : 16;
        localparam int SS = (k % 2 == 1) ? 5 : 1;

        logic          s_rst, s_iv, s_ir, s_ci, s_sub, s_ov, s_or, s_co, s_ovf, s_busy;
        logic [SW-1:0] s_a, s_b, s_sum;
        logic [17:0]   s_q[$];
        logic [17:0]   s_e;
        int            s_xfer;
        logic          d;

        adder_pipe_vr #(.WIDTH(SW), .STAGES(SS)) u_sw (
            .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_ready(s_ir),
            .a(s_a), .b(s_b), .ci(s_ci), .sub(s_sub),
            .out_valid(s_ov), .out_ready(s_or),
            .sum(s_sum), .co(s_co), .ovf(s_ovf), .busy(s_busy)
        );

        always @(negedge clk) begin
            if (!s_rst) begin
                if (s_ov && s_or) begin
                    if (s_q.size() == 0) begin
                        chk($sformatf("sweep%0d_spurious_out", k), 32'(s_ov), 32'd0);
                    end else begin
                        s_e = s_q.pop_front();
                        chk($sformatf("sweep%0d_result", k),
                            32'({s_co, s_ovf, 16'(s_sum)}), 32'(s_e));
                    end
                end
                if (s_iv && s_ir) begin
                    s_q.push_back(ref_model(SW, 16'(s_a), 16'(s_b), s_ci, s_sub));
                    s_xfer++;
                end
            end
        end

        initial begin
            int lat;
            int cyc;
            d = 1'b0; s_rst = 1'b1; s_iv = 1'b0; s_a = '0; s_b = '0;
            s_ci = 1'b0; s_sub = 1'b0; s_or = 1'b1; s_xfer = 0;
            repeat (3) @(posedge clk);
            #1 s_rst = 1'b0;
            @(posedge clk);
            #1;
            s_a = SW'(1); s_b = SW'(1); s_ci = 1'b1; s_sub = 1'b0; s_iv = 1'b1;
            @(posedge clk);
            #1 s_iv = 1'b0;
            lat = 1;
            while (!s_ov && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("sweep%0d_latency", k), 32'(lat), 32'(SS));
            cyc = 0;
            while (s_xfer < 1000 && cyc < 20000) begin
                s_iv  = ($urandom_range(0, 3) != 0);
                s_a   = SW'($urandom);
                s_b   = SW'($urandom);
                s_ci  = 1'($urandom);
                s_sub = 1'($urandom);
                s_or  = ($urandom_range(0, 2) != 0);
                @(posedge clk);
                #1;
                cyc++;
            end
            s_iv = 1'b0;
            s_or = 1'b1;
            cyc = 0;
            while (s_q.size() != 0 && cyc < 100) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            chk($sformatf("sweep%0d_drained", k), 32'(s_q.size()), 32'd0);
            chk($sformatf("sweep%0d_transfers", k), 32'(s_xfer), 32'd1000);
            d = 1'b1;
        end
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic       sub;
        logic [3:0] sum;
        logic       co;
        logic       ovf;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int   lat, cnt, first, last, base_out, t;
        logic [5:0] held;

        tbl[0] = '{4'h7, 4'h8, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0};
        tbl[1] = '{4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0};
        tbl[2] = '{4'h8, 4'h1, 1'b0, 1'b1, 4'h7, 1'b1, 1'b1};
        tbl[3] = '{4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1};
        tbl[4] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
        tbl[5] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0};
        tbl[6] = '{4'h8, 4'h8, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1};
        tbl[7] = '{4'h0, 4'h8, 1'b0, 1'b1, 4'h8, 1'b0, 1'b1};
        tbl[8] = '{4'h5, 4'h3, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        out_ready = 1'b1; cur_exp = '0;
        #22;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum",       32'(sum),       32'd0);
        chk("reset_co",        32'(co),        32'd0);
        chk("reset_ovf",       32'(ovf),       32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Vector table, back-to-back.
        for (int i = 0; i < 9; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, {tbl[i].co, tbl[i].ovf, tbl[i].sum});
        drain("table_drained");

        // Latency with no stall.
        cur_exp = main_exp(4'h2, 4'h3, 1'b0, 1'b0);
        a = 4'h2; b = 4'h3; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd2);
        drain("latency_drained");

        // Eight consecutive transfers must come out as eight consecutive results.
        cnt = 0; first = -1; last = -1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(4'(i), 4'(i), 1'b0, 1'b0, main_exp(4'(i), 4'(i), 1'b0, 1'b0));
            end
            begin
                for (int j = 0; j < 16; j++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        cnt++;
                        if (first < 0) first = j;
                        last = j;
                    end
                end
            end
        join
        chk("b2b_count", 32'(cnt), 32'd8);
        chk("b2b_no_gaps", 32'(last - first), 32'd7);
        @(posedge clk);
        #1;
        drain("b2b_drained");

        // Stall for five cycles with two results pending and a third offered.
        send(4'h9, 4'h2, 1'b0, 1'b0, main_exp(4'h9, 4'h2, 1'b0, 1'b0));
        send(4'hA, 4'h6, 1'b1, 1'b1, main_exp(4'hA, 4'h6, 1'b1, 1'b1));
        out_ready = 1'b0;
        a = 4'hC; b = 4'h3; ci = 1'b0; sub = 1'b0;
        cur_exp = main_exp(4'hC, 4'h3, 1'b0, 1'b0);
        in_valid = 1'b1;
        base_out = n_out;
        @(negedge clk);
        held = {co, ovf, sum};
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready",  32'(in_ready),         32'd0);
            chk("stall_out_valid", 32'(out_valid),        32'd1);
            chk("stall_payload",   32'({co, ovf, sum}),   32'(held));
            chk("stall_busy",      32'(busy),             32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain("stall_drained");
        chk("stall_out_count", 32'(n_out - base_out), 32'd3);

        // Reset with two results in flight.
        send(4'h1, 4'h2, 1'b0, 1'b0, main_exp(4'h1, 4'h2, 1'b0, 1'b0));
        send(4'h3, 4'h4, 1'b0, 1'b0, main_exp(4'h3, 4'h4, 1'b0, 1'b0));
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_sum",       32'(sum),       32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        q_main.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("midrst_no_stale", 32'(cnt), 32'd0);
        chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(4'h5, 4'h5, 1'b1, 1'b0, main_exp(4'h5, 4'h5, 1'b1, 1'b0));
        drain("midrst_drained");

        // Undriven operands during bubbles must not create output.
        a = 'x; b = 'x; in_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) cnt++;
        end
        chk("x_bubble_out_valid", 32'(cnt), 32'd0);
        a = '0; b = '0;

        t = 0;
        while (!(g_sw[0].d && g_sw[1].d && g_sw[2].d && g_sw[3].d) && t < 30000) begin
            @(posedge clk);
            t++;
        end
        chk("sweep_done", 32'({g_sw[3].d, g_sw[2].d, g_sw[1].d, g_sw[0].d}), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
